// File: rtl/opctrl_vc.sv
// Two-virtual-channel router output controller: accepts one granted packet per cycle
// into the FIFO selected by polarity and forwards that FIFO's head downstream.
module opctrl_vc #(
  parameter int DATA_W = 64,
  parameter int NUM_IN = 5,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     polarity,
  input  logic [NUM_IN-1:0]        grant,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic                     receive_output,
  output logic [DATA_W-1:0]        data_out,
  output logic                     send_output,
  output logic [NUM_IN-1:0]        clear,
  output logic [1:0]               vc_empty,
  output logic [1:0]               vc_full,
  output logic                     err_grant
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Pointer wrap is the only modulo step; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      ptr_next = {PTR_W{1'b0}};
    end else begin
      ptr_next = ptr + PTR_W'(1);
    end
  endfunction

  logic [DATA_W-1:0] r_mem [2][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [2];
  logic [PTR_W-1:0]  r_rd_ptr [2];
  logic [CNT_W-1:0]  r_cnt [2];
  logic [DATA_W-1:0] r_data_out;
  logic              r_send;
  logic [NUM_IN-1:0] r_clear;
  logic              r_err;

  logic [NUM_IN-1:0] w_grant_rest;
  logic              w_multi;
  logic              w_onehot;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_sel;

  // Clearing the lowest set bit leaves something only when the grant is multi-hot.
  assign w_grant_rest = grant & (grant - NUM_IN'(1));
  assign w_multi      = |w_grant_rest;
  assign w_onehot     = (|grant) & ~w_multi;

  assign vc_empty = {(r_cnt[1] == CNT_W'(0)), (r_cnt[0] == CNT_W'(0))};
  assign vc_full  = {(r_cnt[1] == CNT_W'(DEPTH)), (r_cnt[0] == CNT_W'(DEPTH))};

  // Full check uses pre-pop occupancy, so a same-cycle pop never frees room.
  assign w_push = w_onehot & ~vc_full[polarity];
  assign w_pop  = receive_output & ~vc_empty[polarity];

  // AND-OR mux of the granted source slice.
  always_comb begin
    w_sel = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      w_sel = w_sel | (data_in[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
    end
  end

  // FIFO storage; contents are only meaningful under the occupancy counter.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[polarity][r_wr_ptr[polarity]] <= w_sel;
    end
  end

  // Pointers, occupancy and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= {DATA_W{1'b0}};
      r_send     <= 1'b0;
      r_clear    <= {NUM_IN{1'b0}};
      r_err      <= 1'b0;
      for (int v = 0; v < 2; v++) begin
        r_wr_ptr[v] <= {PTR_W{1'b0}};
        r_rd_ptr[v] <= {PTR_W{1'b0}};
        r_cnt[v]    <= {CNT_W{1'b0}};
      end
    end else begin
      r_clear <= w_push ? grant : {NUM_IN{1'b0}};
      r_err   <= w_multi;
      r_send  <= w_pop;
      if (w_pop) begin
        r_data_out           <= r_mem[polarity][r_rd_ptr[polarity]];
        r_rd_ptr[polarity]   <= ptr_next(r_rd_ptr[polarity]);
      end
      if (w_push) begin
        r_wr_ptr[polarity] <= ptr_next(r_wr_ptr[polarity]);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt[polarity] <= r_cnt[polarity] + CNT_W'(1);
        2'b01:   r_cnt[polarity] <= r_cnt[polarity] - CNT_W'(1);
        default: r_cnt[polarity] <= r_cnt[polarity];
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign send_output = r_send;
  assign clear       = r_clear;
  assign err_grant   = r_err;

endmodule

// File: tb/tb_opctrl_vc.sv
// Bench for opctrl_vc: DEPTH=2 and DEPTH=3 instances share stimulus and are each
// checked every cycle against a queue-based model of the two virtual channels.
module tb_opctrl_vc;

  localparam int DW = 64;
  localparam int NI = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          polarity;
  logic [NI-1:0] grant;
  logic [NI*DW-1:0] data_in;
  logic          receive_output;

  logic [DW-1:0] dout [2];
  logic          send [2];
  logic [NI-1:0] clr  [2];
  logic [1:0]    emp  [2];
  logic [1:0]    ful  [2];
  logic          err  [2];

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] mq [2][2][$];
  int            mdepth [2] = '{2, 3};
  logic [DW-1:0] exp_dout [2];
  logic          exp_send [2];
  logic [NI-1:0] exp_clr  [2];
  logic          exp_err  [2];

  always #5 clk = ~clk;

  opctrl_vc #(.DATA_W(DW), .NUM_IN(NI), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .polarity(polarity), .grant(grant),
    .data_in(data_in), .receive_output(receive_output),
    .data_out(dout[0]), .send_output(send[0]), .clear(clr[0]),
    .vc_empty(emp[0]), .vc_full(ful[0]), .err_grant(err[0])
  );

  opctrl_vc #(.DATA_W(DW), .NUM_IN(NI), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .polarity(polarity), .grant(grant),
    .data_in(data_in), .receive_output(receive_output),
    .data_out(dout[1]), .send_output(send[1]), .clear(clr[1]),
    .vc_empty(emp[1]), .vc_full(ful[1]), .err_grant(err[1])
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: each VC is a bounded queue; outputs follow from the cycle's inputs.
  task automatic model_step();
    int            ones;
    int            p;
    logic [DW-1:0] sel;
    ones = $countones(grant);
    p    = int'(polarity);
    sel  = '0;
    for (int i = 0; i < NI; i++) begin
      if (grant[i]) sel = sel | data_in[i*DW +: DW];
    end
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mq[d][0].delete();
        mq[d][1].delete();
        exp_dout[d] = '0;
        exp_send[d] = 1'b0;
        exp_clr[d]  = '0;
        exp_err[d]  = 1'b0;
      end else begin
        bit acc;
        bit pop;
        acc = (ones == 1) && (mq[d][p].size() < mdepth[d]);
        pop = receive_output && (mq[d][p].size() > 0);
        exp_send[d] = pop;
        if (pop) exp_dout[d] = mq[d][p].pop_front();
        exp_clr[d] = acc ? grant : '0;
        exp_err[d] = (ones > 1);
        if (acc) mq[d][p].push_back(sel);
      end
    end
  endtask

  task automatic cyc(input logic p, input logic [NI-1:0] g, input logic r, input logic [DW-1:0] v);
    polarity       = p;
    grant          = g;
    receive_output = r;
    for (int i = 0; i < NI; i++) begin
      data_in[i*DW +: DW] = g[i] ? v : ~v;
    end
    model_step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      string s;
      s = $sformatf("dut%0d", d + 2);
      check({s, " data_out"}, dout[d], exp_dout[d]);
      check({s, " send_output"}, DW'(send[d]), DW'(exp_send[d]));
      check({s, " clear"}, DW'(clr[d]), DW'(exp_clr[d]));
      check({s, " err_grant"}, DW'(err[d]), DW'(exp_err[d]));
      check({s, " vc_empty"}, DW'(emp[d]),
            DW'({mq[d][1].size() == 0, mq[d][0].size() == 0}));
      check({s, " vc_full"}, DW'(ful[d]),
            DW'({mq[d][1].size() == mdepth[d], mq[d][0].size() == mdepth[d]}));
    end
  endtask

  initial begin
    reset = 1'b1;
    polarity = 1'b0;
    grant = '0;
    receive_output = 1'b0;
    data_in = '0;
    cyc(1'b0, 5'b00000, 1'b0, 64'h0);
    cyc(1'b1, 5'b00000, 1'b0, 64'h0);
    reset = 1'b0;
    cyc(1'b0, 5'b00000, 1'b1, 64'h0);
    cyc(1'b1, 5'b00000, 1'b1, 64'h0);
    check("reset vc_empty", DW'(emp[0]), DW'(2'b11));

    // Minimum latency, polarity toggling.
    cyc(1'b0, 5'b00100, 1'b1, 64'hA5);
    check("latency clear", DW'(clr[0]), DW'(5'b00100));
    cyc(1'b1, 5'b00000, 1'b1, 64'h0);
    cyc(1'b0, 5'b00000, 1'b1, 64'h0);
    check("latency data_out", dout[0], 64'hA5);
    cyc(1'b1, 5'b00000, 1'b1, 64'h0);

    // Fill VC0 with the downstream stalled, then drain.
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 5'b00010, 1'b0, DW'(k));
      cyc(1'b1, 5'b00000, 1'b0, 64'h0);
    end
    check("full vc0 depth2", DW'(ful[0]), DW'(2'b01));
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 5'b00000, 1'b1, 64'h0);
      cyc(1'b1, 5'b00000, 1'b1, 64'h0);
    end

    // Multi-hot grant with one entry held in VC0.
    cyc(1'b0, 5'b01000, 1'b0, 64'h55);
    cyc(1'b0, 5'b00011, 1'b0, 64'h66);
    check("multihot err", DW'(err[0]), DW'(1'b1));
    cyc(1'b0, 5'b00000, 1'b0, 64'h0);

    // Simultaneous push/pop on half-full VC0.
    cyc(1'b0, 5'b10000, 1'b1, 64'h77);
    cyc(1'b1, 5'b00000, 1'b1, 64'h0);
    cyc(1'b0, 5'b00000, 1'b1, 64'h0);

    // Wrap-around through VC1.
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 5'b00000, (k > 3), 64'h0);
      cyc(1'b1, 5'b00001, (k > 3), DW'(k + 100));
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 5'b00000, 1'b1, 64'h0);
      cyc(1'b1, 5'b00000, 1'b1, 64'h0);
    end

    // Reset with both VCs holding data.
    cyc(1'b0, 5'b00001, 1'b0, 64'h11);
    cyc(1'b1, 5'b00100, 1'b0, 64'h22);
    reset = 1'b1;
    cyc(1'b0, 5'b00001, 1'b1, 64'h33);
    reset = 1'b0;
    check("reset midop vc_empty", DW'(emp[1]), DW'(2'b11));

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic          p;
      logic [NI-1:0] g;
      int            sel;
      p   = ($urandom_range(0, 9) == 0) ? 1'($urandom) : 1'(k);
      sel = $urandom_range(0, 9);
      if (sel < 3)      g = '0;
      else if (sel < 8) g = NI'(1) << $urandom_range(0, NI - 1);
      else              g = NI'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      cyc(p, g, ($urandom_range(0, 3) != 0), {$urandom, $urandom});
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
